// File: rtl/gnr_sim_ctrl.sv
// Sequencer for a gene-network node array: load, then alternate s0/s1 update strobes per iteration.
// Latency: start at edge T -> LOAD at T+1, CAPT at T+2, first snapshot valid at T+3; 4 cycles per further iteration.
// Backpressure: a snapshot holds in EMIT until out_ready; no strobes are issued while stalled, so nodes stay frozen.
module gnr_sim_ctrl #(
    parameter int NUM_NODES = 188,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] init_in,
    input  logic [CNT_W-1:0]     num_iter,
    input  logic [NUM_NODES-1:0] state_in,
    output logic                 reset_nos,
    output logic                 start_s0,
    output logic                 start_s1,
    output logic [NUM_NODES-1:0] init_state,
    output logic [NUM_NODES-1:0] out_data,
    output logic [CNT_W-1:0]     out_iter,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CAPT  = 3'd2,
        S_EMIT  = 3'd3,
        S_EVAL0 = 3'd4,
        S_EVAL1 = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] iter_cnt;
    logic [CNT_W-1:0] num_iter_q;

    logic reset_nos_d;
    logic start_s0_d;
    logic start_s1_d;
    logic out_valid_d;
    logic busy_d;
    logic done_d;

    logic start_acc;
    logic snap_hs;
    logic last_iter;

    assign start_acc = (state == S_IDLE) && start;
    assign snap_hs   = (state == S_EMIT) && out_valid && out_ready;
    assign last_iter = (iter_cnt == num_iter_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; start outside IDLE is simply not looked at.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  next_state = S_CAPT;
            S_CAPT:  next_state = S_EMIT;
            S_EMIT:  if (snap_hs) next_state = last_iter ? S_FIN : S_EVAL0;
            S_EVAL0: next_state = S_EVAL1;
            S_EVAL1: next_state = S_CAPT;
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the state being entered, so every strobe leaves a flop.
    always_comb begin
        reset_nos_d = (next_state == S_LOAD);
        start_s0_d  = (next_state == S_EVAL0);
        start_s1_d  = (next_state == S_EVAL1);
        out_valid_d = (next_state == S_EMIT);
        busy_d      = (next_state != S_IDLE);
        done_d      = (next_state == S_FIN);
    end

    // Registered control outputs; rst drops everything, including a pending snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            reset_nos <= reset_nos_d;
            start_s0  <= start_s0_d;
            start_s1  <= start_s1_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Run parameters, iteration counter and snapshot capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_state <= '0;
            num_iter_q <= '0;
            iter_cnt   <= '0;
            out_data   <= '0;
            out_iter   <= '0;
        end else begin
            if (start_acc) begin
                init_state <= init_in;
                num_iter_q <= num_iter;
                iter_cnt   <= '0;
            end
            // Nodes committed on the edge ending LOAD/EVAL1, so state_in is settled here.
            if (state == S_CAPT) begin
                out_data <= state_in;
                out_iter <= iter_cnt;
            end
            if (snap_hs && !last_iter) begin
                iter_cnt <= iter_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_gnr_sim_ctrl.sv
module tb_gnr_sim_ctrl;

    localparam int NN = 188;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, out_ready;
    logic [NN-1:0] init_in, state_in;
    logic [CW-1:0] num_iter;
    logic          reset_nos, start_s0, start_s1, out_valid, busy, done;
    logic [NN-1:0] init_state, out_data;
    logic [CW-1:0] out_iter;

    gnr_sim_ctrl #(.NUM_NODES(NN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .init_in(init_in), .num_iter(num_iter),
        .state_in(state_in), .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
        .init_state(init_state), .out_data(out_data), .out_iter(out_iter),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    // Narrow instance so the all-ones iteration bound can be run end to end.
    logic       s_start, s_ready, s_rn, s_s0, s_s1, s_valid, s_busy, s_done;
    logic [7:0] s_init, s_niter, s_init_state, s_data, s_iter;

    gnr_sim_ctrl #(.NUM_NODES(8), .CNT_W(8)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .init_in(s_init), .num_iter(s_niter),
        .state_in(s_init_state), .reset_nos(s_rn), .start_s0(s_s0), .start_s1(s_s1),
        .init_state(s_init_state), .out_data(s_data), .out_iter(s_iter),
        .out_valid(s_valid), .out_ready(s_ready), .busy(s_busy), .done(s_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Node update rule used by both the node array model and the reference.
    function automatic logic [NN-1:0] step(input logic [NN-1:0] x);
        return {x[NN-2:0], ~x[NN-1]};
    endfunction

    function automatic logic [NN-1:0] rnd_vec();
        logic [NN-1:0] v;
        for (int i = 0; i < NN; i++) v[i] = ($urandom_range(0, 1) == 1);
        return v;
    endfunction

    // Node array: load on reset_nos, evaluate on s0, commit on s1.
    logic [NN-1:0] nodes, pend;
    initial begin
        nodes = '0;
        pend  = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                nodes = '0;
                pend  = '0;
            end else begin
                if (start_s0) pend = step(nodes);
                if (start_s1) nodes = pend;
                if (reset_nos) nodes = init_state;
            end
        end
    end
    assign state_in = nodes;

    // Consumer ready driver.
    int rdy_mode = 0;
    int stall_left = 0;
    initial begin
        out_ready = 1'b0;
        s_ready   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s_ready = ($urandom_range(0, 1) == 1);
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 1) == 1);
                default: begin
                    if (out_valid && out_iter == 16'd1 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    int cyc = 0;
    int n_rn, n_s0, n_s1, n_done, n_snap, viol, tag_err, data_err, t_rn, t_done, t_busy;
    int hs_cyc[$];
    int vr_cyc[$];
    logic [CW-1:0] exp_tag;
    logic [NN-1:0] exp_data;
    logic p_s0, p_rn, p_valid, p_ready, p_hs, p_busy, p_done, p_rs, pp_rs;
    logic [NN-1:0] p_data;
    logic [CW-1:0] p_iter;
    int s_n, s_nd, s_terr, s_derr;
    logic [7:0] s_exp, s_last;

    initial begin
        p_s0 = 0; p_rn = 0; p_valid = 0; p_ready = 0; p_hs = 0; p_busy = 0; p_done = 0;
        p_rs = 0; pp_rs = 0; p_data = '0; p_iter = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                p_s0 = 0; p_rn = 0; p_valid = 0; p_ready = 0; p_hs = 0; p_busy = 0; p_done = 0;
                p_rs = 0; pp_rs = 0;
            end else begin
                int nstr;
                logic hs;
                hs   = out_valid && out_ready;
                nstr = int'(reset_nos) + int'(start_s0) + int'(start_s1);
                if (nstr > 1) viol++;
                if (reset_nos && p_rn) viol++;
                if (start_s0 && (p_s0 || !p_hs)) viol++;
                if (start_s1 && !p_s0) viol++;
                if (done && (!p_hs || !busy)) viol++;
                if (!busy && p_busy && !p_done) viol++;
                if (p_valid && !p_ready &&
                    (!out_valid || out_data !== p_data || out_iter !== p_iter || nstr != 0)) viol++;
                if (out_valid && !p_valid) begin
                    if (!pp_rs) viol++;
                    vr_cyc.push_back(cyc);
                end
                if (busy && !p_busy) t_busy = cyc;
                if (reset_nos) begin n_rn++; t_rn = cyc; end
                if (start_s0) n_s0++;
                if (start_s1) n_s1++;
                if (done) begin n_done++; t_done = cyc; end
                if (hs) begin
                    n_snap++;
                    hs_cyc.push_back(cyc);
                    if (out_iter !== exp_tag) tag_err++;
                    if (out_data !== exp_data) data_err++;
                    exp_tag  = exp_tag + 16'd1;
                    exp_data = step(exp_data);
                end
                pp_rs = p_rs;
                p_rs = reset_nos || start_s1;
                p_s0 = start_s0; p_rn = reset_nos; p_valid = out_valid; p_ready = out_ready;
                p_hs = hs; p_busy = busy; p_done = done; p_data = out_data; p_iter = out_iter;
                if (s_valid && s_ready) begin
                    if (s_iter !== s_exp) s_terr++;
                    if (s_data !== 8'hA5) s_derr++;
                    s_last = s_iter;
                    s_exp  = s_exp + 8'd1;
                    s_n++;
                end
                if (s_done) s_nd++;
            end
        end
    end

    task automatic reset_stats(input logic [NN-1:0] pat);
        n_rn = 0; n_s0 = 0; n_s1 = 0; n_done = 0; n_snap = 0; viol = 0;
        tag_err = 0; data_err = 0; t_rn = -1; t_done = -1; t_busy = -1;
        hs_cyc.delete();
        vr_cyc.delete();
        exp_tag = '0;
        exp_data = pat;
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, ":valid0"}, 256'(out_valid), 256'(0));
        check({nm, ":busy0"}, 256'(busy), 256'(0));
        check({nm, ":strobes0"}, 256'({reset_nos, start_s0, start_s1, done}), 256'(0));
        check({nm, ":init0"}, 256'(init_state), 256'(0));
        check({nm, ":data0"}, 256'(out_data), 256'(0));
        check({nm, ":iter0"}, 256'(out_iter), 256'(0));
    endtask

    task automatic run(input string nm, input logic [NN-1:0] pat, input logic [CW-1:0] n,
                       input int mode, input int inj, input int rst_at, input int bound);
        int t_start, k, s0seen;
        bit did1, did2, aborted;
        reset_stats(pat);
        rdy_mode = mode;
        stall_left = 10;
        did1 = 0; did2 = 0; s0seen = 0; aborted = 0;
        @(posedge clk);
        #2;
        start = 1'b1;
        init_in = pat;
        num_iter = n;
        t_start = cyc + 1;
        k = 0;
        while (n_done == 0 && k < bound && !aborted) begin
            @(posedge clk);
            #2;
            k++;
            start = 1'b0;
            init_in = rnd_vec();
            num_iter = CW'($urandom);
            if (inj != 0 && start_s1 && !did1) begin start = 1'b1; did1 = 1; end
            if (inj != 0 && out_valid && !out_ready && !did2) begin start = 1'b1; did2 = 1; end
            if (start_s0) s0seen++;
            if (rst_at != 0 && start_s0 && s0seen == rst_at) aborted = 1;
        end
        if (aborted) begin
            rst = 1'b1;
            start = 1'b0;
            @(posedge clk);
            #1;
            check_idle_zero({nm, ":midrst"});
            rst = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            check({nm, ":no_done"}, 256'(n_done), 256'(0));
            check({nm, ":still_idle"}, 256'({busy, out_valid}), 256'(0));
        end else begin
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            if (k >= bound) check({nm, ":timeout"}, 256'(k), 256'(0));
            check({nm, ":done_cnt"}, 256'(n_done), 256'(1));
            check({nm, ":snaps"}, 256'(n_snap), 256'(n) + 256'(1));
            check({nm, ":tag_err"}, 256'(tag_err), 256'(0));
            check({nm, ":data_err"}, 256'(data_err), 256'(0));
            check({nm, ":viol"}, 256'(viol), 256'(0));
            check({nm, ":rn_cnt"}, 256'(n_rn), 256'(1));
            check({nm, ":s0_cnt"}, 256'(n_s0), 256'(n));
            check({nm, ":s1_cnt"}, 256'(n_s1), 256'(n));
            check({nm, ":init_state"}, 256'(init_state), 256'(pat));
            check({nm, ":busy_end"}, 256'(busy), 256'(0));
            check({nm, ":t_busy"}, 256'(t_busy), 256'(t_start + 1));
            check({nm, ":t_load"}, 256'(t_rn), 256'(t_start + 1));
            check({nm, ":t_valid"}, 256'((vr_cyc.size() > 0) ? vr_cyc[0] : -5), 256'(t_start + 3));
            check({nm, ":t_done"}, 256'(t_done),
                  256'((hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] + 1 : -5));
        end
    endtask

    initial begin
        logic [NN-1:0] pat5;
        int k;
        rst = 1'b1; start = 1'b0; init_in = '0; num_iter = '0;
        s_start = 1'b0; s_init = '0; s_niter = '0;
        s_n = 0; s_nd = 0; s_terr = 0; s_derr = 0; s_exp = '0; s_last = '0;
        reset_stats('0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NN; i++) pat5[i] = (i % 2 == 0);
        run("n0", pat5, 16'd0, 0, 0, 0, 200);
        check("n0:no_stall", 256'((hs_cyc.size() > 0) ? hs_cyc[0] : -5),
              256'((vr_cyc.size() > 0) ? vr_cyc[0] : -9));

        run("n3", rnd_vec(), 16'd3, 0, 0, 0, 200);
        for (int i = 0; i < 3; i++)
            check($sformatf("n3:gap%0d", i),
                  256'((hs_cyc.size() > i + 1) ? hs_cyc[i+1] - hs_cyc[i] : -5), 256'(4));

        run("stall", rnd_vec(), 16'd2, 2, 0, 0, 300);
        check("stall:len", 256'((hs_cyc.size() > 1 && vr_cyc.size() > 1) ? hs_cyc[1] - vr_cyc[1] : -5),
              256'(10));

        run("busy_start", rnd_vec(), 16'd2, 2, 1, 0, 300);

        run("midrst", rnd_vec(), 16'd3, 0, 0, 2, 300);
        run("after_rst", rnd_vec(), 16'd2, 0, 0, 0, 200);

        run("rand_rdy", rnd_vec(), 16'd20, 1, 0, 0, 3000);

        @(posedge clk);
        #2;
        s_start = 1'b1; s_init = 8'hA5; s_niter = 8'hFF;
        @(posedge clk);
        #2;
        s_start = 1'b0;
        k = 0;
        while (s_nd == 0 && k < 8000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("wrap:done_cnt", 256'(s_nd), 256'(1));
        check("wrap:snaps", 256'(s_n), 256'(256));
        check("wrap:tag_err", 256'(s_terr), 256'(0));
        check("wrap:data_err", 256'(s_derr), 256'(0));
        check("wrap:last_tag", 256'(s_last), 256'(8'hFF));
        check("wrap:busy_end", 256'(s_busy), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
